// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and FSM encoding for the SPI master/slave pair.
//   SPI_CLK_DIV : default system clocks per sclk half-period
//   SPI_DATA_W  : bits per transfer, shared with spi_slave
//   state_e     : 3-bit master FSM state encoding
package spi_pkg;
    localparam int SPI_CLK_DIV = 4;
    localparam int SPI_DATA_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_BIT_HI   = 3'd2,
        ST_BIT_LO   = 3'd3,
        ST_HOLD     = 3'd4,
        ST_LATCH_HI = 3'd5,
        ST_LATCH_LO = 3'd6
    } state_e;
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period tick generator for the SPI master.
//   clk, rst : system clock, synchronous active-high reset
//   clear    : hold the counter at zero (master idle)
//   load     : restart the half-period count (state entry)
//   tick     : 1-cycle pulse on the last cycle of each CLK_DIV-cycle period
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic load,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = !clear && (cnt_q == LAST);
        cnt_d = (clear || load || tick) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/spi_master.sv
// spi_master: single-transfer LSB-first SPI master with trailing latch pulse.
//   clk, rst : system clock, synchronous active-high reset
//   start    : transfer request, sampled only while idle
//   tx_data  : byte to send, latched on start acceptance
//   busy     : transfer in progress
//   done     : 1-cycle pulse at completion
//   rx_data  : byte captured from miso, updated at completion
//   sclk     : SPI clock, idle low
//   cs       : slave select, active low
//   mosi     : serial data out, LSB first
//   miso     : serial data in
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV,
    parameter int DATA_W  = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              cs,
    output logic              mosi,
    input  logic              miso
);
    localparam int BW = $clog2(DATA_W + 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              busy_q, busy_d, done_q, done_d, sclk_q, sclk_d;
    logic              cs_q, cs_d, mosi_q, mosi_d;
    logic              tick, load;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == ST_IDLE),
        .load  (load),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d   = ST_SETUP;
                tx_sh_d   = tx_data;
                bit_cnt_d = '0;
            end
            ST_SETUP:    if (tick) state_d = ST_BIT_HI;
            ST_BIT_HI:   if (tick) state_d = ST_BIT_LO;
            ST_BIT_LO: if (tick) begin
                rx_sh_d   = {miso, rx_sh_q[DATA_W-1:1]};
                tx_sh_d   = tx_sh_q >> 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                state_d   = (bit_cnt_d == BW'(DATA_W)) ? ST_HOLD : ST_BIT_HI;
            end
            ST_HOLD:     if (tick) state_d = ST_LATCH_HI;
            ST_LATCH_HI: if (tick) state_d = ST_LATCH_LO;
            ST_LATCH_LO: if (tick) begin
                state_d   = ST_IDLE;
                rx_data_d = rx_sh_q;
                done_d    = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        // Outputs are decoded from the next state so they are registered yet
        // line up with the state they belong to.
        load   = state_d != state_q;
        busy_d = state_d != ST_IDLE;
        cs_d   = state_d inside {ST_IDLE, ST_HOLD, ST_LATCH_HI, ST_LATCH_LO};
        sclk_d = state_d inside {ST_BIT_HI, ST_LATCH_HI};
        mosi_d = (state_d inside {ST_BIT_HI, ST_BIT_LO}) && tx_sh_d[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            bit_cnt_q <= bit_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            mosi_q    <= mosi_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign cs      = cs_q;
    assign mosi    = mosi_q;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed self-checking bench for spi_master (CLK_DIV=2 with a
// behavioural slave, CLK_DIV=1 with loopback / tied miso).
module tb_spi_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_start = 1'b0, a_miso = 1'b0;
    logic [7:0] a_tx = '0, a_rx;
    logic       a_busy, a_done, a_sclk, a_cs, a_mosi;

    logic       b_start = 1'b0, b_sel = 1'b0, b_miso;
    logic [7:0] b_tx = '0, b_rx;
    logic       b_busy, b_done, b_sclk, b_cs, b_mosi;

    assign b_miso = b_sel ? 1'b0 : b_mosi;

    spi_master #(.CLK_DIV(2), .DATA_W(8)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .tx_data(a_tx), .busy(a_busy),
        .done(a_done), .rx_data(a_rx), .sclk(a_sclk), .cs(a_cs), .mosi(a_mosi),
        .miso(a_miso)
    );

    spi_master #(.CLK_DIV(1), .DATA_W(8)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .tx_data(b_tx), .busy(b_busy),
        .done(b_done), .rx_data(b_rx), .sclk(b_sclk), .cs(b_cs), .mosi(b_mosi),
        .miso(b_miso)
    );

    // Behavioural slave on instance A: shifts right on sclk fall while
    // selected, publishes data_out on an sclk rise with cs high after 8 bits.
    int         a_busy_cnt = 0, a_done_cnt = 0, s_falls = 0, s_cnt = 0;
    logic [7:0] s_sh = '0, s_out = '0;
    logic       a_sclk_p = 1'b0, a_cs_p = 1'b1;

    always @(negedge clk) begin
        if (a_busy) a_busy_cnt++;
        if (a_done) a_done_cnt++;
        if (a_cs_p && !a_cs) s_cnt = 0;
        if (a_sclk_p && !a_sclk && !a_cs) begin
            s_sh = {a_mosi, s_sh[7:1]};
            s_cnt++;
            s_falls++;
        end
        if (!a_sclk_p && a_sclk && a_cs && s_cnt == 8) begin
            s_out = s_sh;
            s_cnt = 0;
        end
        a_sclk_p = a_sclk;
        a_cs_p   = a_cs;
    end

    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    int          k, rise_k, d0, b0, f0;
    logic [15:0] sv;

    initial begin
        repeat (3) step();
        check("rst_cs", a_cs, 1);
        check("rst_sclk", a_sclk, 0);
        check("rst_mosi", a_mosi, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_rx", a_rx, 0);
        check("rst_b_cs", b_cs, 1);
        rst = 1'b0;
        step();

        // A5 with miso tied high, CLK_DIV=2: 20 states x 2 cycles.
        a_miso = 1'b1;
        b0 = a_busy_cnt; d0 = a_done_cnt; f0 = s_falls;
        a_tx = 8'hA5; a_start = 1'b1;
        step(); a_start = 1'b0; k = 1; rise_k = 0;
        check("a5_busy_t1", a_busy, 1);
        check("a5_cs_t1", a_cs, 0);
        while (!a_done && k < 200) begin
            if (a_sclk && rise_k == 0) rise_k = k;
            step(); k++;
        end
        check("a5_first_rise", rise_k, 3);
        check("a5_done_cycle", k, 41);
        check("a5_busy_cycles", a_busy_cnt - b0, 40);
        check("a5_done_count", a_done_cnt - d0, 1);
        check("a5_bit_falls", s_falls - f0, 8);
        check("a5_mosi_bits", s_sh, {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
        check("a5_slave_out", s_out, 8'hA5);
        check("a5_rx_ones", a_rx, 8'hFF);
        check("a5_busy_at_done", a_busy, 0);
        step();
        check("a5_done_pulse", a_done, 0);

        // 12 transfer with a spurious FF start mid-way.
        d0 = a_done_cnt;
        a_tx = 8'h12; a_start = 1'b1;
        step(); a_start = 1'b0; k = 1;
        while (!a_done && k < 200) begin
            if (k == 6) begin a_tx = 8'hFF; a_start = 1'b1; end
            else a_start = 1'b0;
            step(); k++;
        end
        check("mid_done_cycle", k, 41);
        check("mid_slave_out", s_out, 8'h12);
        repeat (10) step();
        check("mid_done_count", a_done_cnt - d0, 1);
        check("mid_idle_after", a_busy, 0);

        // Reset at the 4th sclk fall of a 5A transfer.
        a_tx = 8'h5A; a_start = 1'b1;
        step(); a_start = 1'b0; f0 = s_falls; k = 0;
        while (s_falls < f0 + 4 && k < 200) begin step(); k++; end
        check("abort_reached", s_falls - f0, 4);
        rst = 1'b1; d0 = a_done_cnt;
        step();
        check("abort_cs", a_cs, 1);
        check("abort_sclk", a_sclk, 0);
        check("abort_busy", a_busy, 0);
        check("abort_rx", a_rx, 0);
        check("abort_done", a_done, 0);
        rst = 1'b0;
        repeat (50) step();
        check("abort_no_done", a_done_cnt - d0, 0);
        check("abort_slave_kept", s_out, 8'h12);

        // Back-to-back: start held, 01 then 80.
        a_tx = 8'h01; a_start = 1'b1;
        step(); k = 1;
        while (!a_done && k < 200) begin step(); k++; end
        check("b2b_first_cycle", k, 41);
        check("b2b_first_out", s_out, 8'h01);
        a_tx = 8'h80;
        step();
        a_start = 1'b0;
        check("b2b_cs_next", a_cs, 0);
        check("b2b_busy_next", a_busy, 1);
        k = 1;
        while (!a_done && k < 200) begin step(); k++; end
        check("b2b_second_cycle", k, 41);
        check("b2b_second_out", s_out, 8'h80);

        // CLK_DIV=1 loopback: sclk alternates every cycle over the 16 bit states.
        b_sel = 1'b0; b_tx = 8'h3C; b_start = 1'b1;
        step(); b_start = 1'b0; k = 1; sv = '0;
        while (!b_done && k < 200) begin
            if (k >= 2 && k <= 17) sv[k-2] = b_sclk;
            step(); k++;
        end
        check("lb_done_cycle", k, 21);
        check("lb_sclk_pattern", sv, 16'h5555);
        check("lb_rx", b_rx, 8'h3C);

        // CLK_DIV=1, miso tied low.
        step();
        b_sel = 1'b1; b_tx = 8'hA5; b_start = 1'b1;
        step(); b_start = 1'b0; k = 1;
        while (!b_done && k < 200) begin step(); k++; end
        check("zero_done_cycle", k, 21);
        check("zero_rx", b_rx, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
